regfile: RTL
============

# regfile

Integer register file and issue scoreboard for the RV32 core. It sits between the ID stage, which reads operands and marks destinations busy, and the WB stage, which writes results back. It provides two combinational read ports with write-through bypass from the WB write port, and a hardwired-zero x0. After reset it clears every register with a sequencer and signals readiness. A per-register busy scoreboard lets ID stall on read-after-write hazards.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width (2^REG_AW registers)
- clk  in  1  core clock
- rst_b  in  1  reset; asynchronous, active-low
- wb_rd_write  in  1  WB write enable, already qualified by WB valid
- wb_rd_addr  in  REG_AW  WB destination register
- wb_rd_wdata  in  XLEN  WB write data
- id_rs1_addr  in  REG_AW  read port 1 address
- id_rs2_addr  in  REG_AW  read port 2 address
- id_rs1_rdata  out  XLEN  read port 1 data
- id_rs2_rdata  out  XLEN  read port 2 data
- id_rs1_busy  out  1  rs1 has an outstanding writer
- id_rs2_busy  out  1  rs2 has an outstanding writer
- id_rd_issue  in  1  ID issues an instruction that writes rd
- id_rd_addr  in  REG_AW  destination of the issuing instruction
- sb_flush  in  1  clear all busy bits
- rf_ready  out  1  clear sequence complete; core may issue

## Operation
- **FSM states:** INIT and RUN.
- **Reset:** reset forces state INIT, clear index 0, all busy bits 0, and rf_ready 0.
  - Register contents are not reset asynchronously; the INIT sequencer clears them.
- **INIT:**
  - Each clock writes 0 to register[idx] and increments idx.
  - On the cycle idx reaches 2^REG_AW-1, the FSM moves to RUN and rf_ready goes high.
  - wb_rd_write, id_rd_issue and sb_flush are ignored in INIT.
  - Read ports return 0 in INIT.
- **RUN write:** when wb_rd_write=1 and wb_rd_addr≠0, register[wb_rd_addr] ← wb_rd_wdata on the clock edge.
  - Writes to x0 are discarded.
- **RUN read:** read data is combinational.
  - Address 0 returns 0.
  - Otherwise, if wb_rd_write=1 and the address equals wb_rd_addr, the port returns wb_rd_wdata (bypass).
  - Otherwise the port returns the stored register value.
- **Scoreboard set:** id_rd_issue=1 with id_rd_addr≠0 sets busy[id_rd_addr] on the clock edge.
- **Scoreboard clear:** wb_rd_write=1 clears busy[wb_rd_addr] on the clock edge.
- **Same-cycle set and clear on one register:** set wins. The newer writer is outstanding.
- **Busy outputs:**
  - id_rsN_busy = busy[id_rsN_addr], except it is 0 when the address is 0.
  - It is also 0 when wb_rd_write=1 hits that address in the same cycle, because the bypass makes the data valid.
- **sb_flush:** clears every busy bit and takes priority over issue and clear in the same cycle.
  - The asserting party guarantees no older writer remains in EX/MEM/WB.
- **x0:** never busy, never written, always reads 0.

## Timing
- Read latency is 0 cycles (combinational).
- Write is visible to non-bypassed reads 1 cycle after the edge.
- Busy-bit update latency is 1 edge.
- rf_ready is registered and rises after the 2^REG_AW-th rising edge following rst_b deassertion (32 edges by default).
- Reset values of outputs:
  - rf_ready=0
  - id_rs1_busy and id_rs2_busy = 0
  - id_rs1_rdata and id_rs2_rdata = 0
- Reset asserted mid-INIT or mid-RUN aborts immediately to INIT at idx 0 and restarts the full clear.
- The clear index wraps nowhere: the FSM leaves INIT at the terminal count.
- Back-to-back writes to the same register: the last edge wins.

## Structure
- XLEN and REG_AW come from the shared core macros (core.svh/config.svh).
- Add an rf_state_e typedef (INIT, RUN) to the core package.
- Sub-module regfile_scoreboard holds:
  - the busy vector;
  - set/clear/flush priority;
  - busy lookup with same-cycle WB masking for both read ports.
- Storage, the INIT sequencer and the bypass muxes stay in regfile.

## Test plan
- **Reset clear:** deassert rst_b, then read all 32 addresses after rf_ready.
  - rf_ready rises exactly 32 edges after deassert.
  - All reads return 0x00000000.
- **Write/read:** write x5=0xDEADBEEF, then read rs1=5 the next cycle.
  - Returns 0xDEADBEEF.
  - Writing x0=0x12345678 still reads 0.
- **Bypass:** rs2_addr=7, and wb writes x7=0xA5A5A5A5 in the same cycle.
  - id_rs2_rdata=0xA5A5A5A5 in that cycle.
  - id_rs2_busy=0 in that cycle even if busy[7] was set.
- **Scoreboard:** issue rd=3, so rs1=3 busy=1. Next, issue rd=3 and WB write x3 in the same cycle.
  - busy[3] stays 1.
  - A following WB write to x3 clears it.
- **Flush:** set busy on x1, x2 and x31, then pulse sb_flush together with id_rd_issue rd=4.
  - All busy bits read 0 the next cycle, including x4.
- **Reset mid-run:** after writing x9=0x1, assert rst_b low for 1 cycle.
  - rf_ready=0 asynchronously.
  - The full 32-cycle clear reruns.
  - x9 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file: default geometry and
// the clear-sequencer state type.
package regfile_pkg;

  localparam int unsigned RF_XLEN   = 32;
  localparam int unsigned RF_REG_AW = 5;

  typedef enum logic {
    INIT,
    RUN
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush > issue-set > writeback-clear, with
// lookups masked when the writeback in the same cycle makes the data valid.
module regfile_scoreboard #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      // Applied after the clear so a newer writer stays outstanding.
      if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rs1_busy_o = (rs1_addr_i != '0) && busy_q[rs1_addr_i]
                 && !(clr_en_i && (clr_addr_i == rs1_addr_i));
    rs2_busy_o = (rs2_addr_i != '0) && busy_q[rs2_addr_i]
                 && !(clr_en_i && (clr_addr_i == rs2_addr_i));
  end

endmodule

// File: rtl/regfile.sv
// RV32 integer register file: post-reset clear sequencer, two bypassed
// combinational read ports, hardwired-zero x0 and an issue scoreboard.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned REG_AW = RF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_wdata,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  output logic [XLEN-1:0]   id_rs1_rdata,
  output logic [XLEN-1:0]   id_rs2_rdata,
  output logic              id_rs1_busy,
  output logic              id_rs2_busy,
  input  logic              id_rd_issue,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              sb_flush,
  output logic              rf_ready
);

  localparam int unsigned NREG = 1 << REG_AW;

  rf_state_e         state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   regs_q [NREG];
  logic              run;
  logic              wb_we;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        if (idx_q == '1) state_d = RUN;
        else             idx_d   = idx_q + 1'b1;
      end
      RUN:     ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign run      = (state_q == RUN);
  assign wb_we    = run && wb_rd_write;
  assign rf_ready = run;

  // Contents are cleared by the sequencer rather than by reset.
  always_ff @(posedge clk) begin
    if (!run)                             regs_q[idx_q]      <= '0;
    else if (wb_we && (wb_rd_addr != '0)) regs_q[wb_rd_addr] <= wb_rd_wdata;
  end

  always_comb begin
    id_rs1_rdata = regs_q[id_rs1_addr];
    if (!run || (id_rs1_addr == '0))            id_rs1_rdata = '0;
    else if (wb_we && (wb_rd_addr == id_rs1_addr)) id_rs1_rdata = wb_rd_wdata;

    id_rs2_rdata = regs_q[id_rs2_addr];
    if (!run || (id_rs2_addr == '0))            id_rs2_rdata = '0;
    else if (wb_we && (wb_rd_addr == id_rs2_addr)) id_rs2_rdata = wb_rd_wdata;
  end

  regfile_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_b      (rst_b),
    .set_en_i   (run && id_rd_issue),
    .set_addr_i (id_rd_addr),
    .clr_en_i   (wb_we),
    .clr_addr_i (wb_rd_addr),
    .flush_i    (run && sb_flush),
    .rs1_addr_i (id_rs1_addr),
    .rs2_addr_i (id_rs2_addr),
    .rs1_busy_o (id_rs1_busy),
    .rs2_busy_o (id_rs2_busy)
  );

endmodule
